seven_seg_capture: RTL

Receive-side counterpart of the board's time-multiplexed seven-segment display path. It samples an active-low segment bus and its active-low anode strobes, and filters out scan transitions and glitches. It decodes each stable pattern back to a 4-bit hex value and keeps a per-digit register file of the four displayed values. It is used for display loopback checking and as an on-board monitor.

---
 rtl/seven_seg_capture_if.sv | 25 ++
 rtl/seven_seg_capture.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture_if.sv
// Signal bundle between a seven-segment display source and the capture block.
// The master side drives the display bus and clear; the slave side returns
// the recovered digits and status.
interface seven_seg_capture_if;
  logic [6:0] segs;
  logic [3:0] an;
  logic       clear;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] valid;
  logic [3:0] err;
  logic       frame_done;

  modport master (
    output segs, an, clear,
    input  digit0, digit1, digit2, digit3, valid, err, frame_done
  );

  modport slave (
    input  segs, an, clear,
    output digit0, digit1, digit2, digit3, valid, err, frame_done
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Seven-segment receive monitor: samples the active-low segment/anode bus,
// waits for a pattern to stay put for STABLE_CYCLES samples, decodes it back
// to a hex value and stores it per digit position.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input logic            clk,
  input logic            reset,
  seven_seg_capture_if.slave bus
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RMAX = RW'(STABLE_CYCLES);
  localparam logic [10:0] SAMPLE_IDLE = 11'h7FF;

  logic [10:0]   sample_q, sample_d;
  logic [RW-1:0] run_q, run_d;
  logic          fired_q, fired_d;
  logic [3:0]    digit_q [4];
  logic [3:0]    digit_d [4];
  logic [3:0]    valid_q, valid_d;
  logic [3:0]    err_q, err_d;
  logic [3:0]    seen_q, seen_d;
  logic          frame_q, frame_d;

  logic [10:0] sampleIn;
  logic        inLegal;
  logic        sameSample;
  logic        accept;
  logic        decOk;
  logic [3:0]  decVal;
  logic [1:0]  pos;
  logic [3:0]  seenNext;

  // Exactly one low anode bit makes a sample usable.
  function automatic logic anodeLegal(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  // Map an active-low glyph back to its hex value; {ok, value}.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Run tracking: the incoming sample is compared to the held one so that the
  // count reflects how many consecutive samples the register will have held.
  always_comb begin
    sampleIn   = {bus.an, bus.segs};
    sample_d   = sampleIn;
    inLegal    = anodeLegal(bus.an);
    sameSample = (sampleIn == sample_q);
    accept     = (run_q == RMAX) && !fired_q;

    run_d = '0;
    if (inLegal) begin
      if (sameSample) begin
        run_d = (run_q == RMAX) ? run_q : run_q + RW'(1);
      end else begin
        run_d = RW'(1);
      end
    end

    fired_d = (inLegal && sameSample) ? (fired_q | accept) : 1'b0;
  end

  // Decode the held pattern and work out the register-file update.
  always_comb begin
    {decOk, decVal} = decodeGlyph(sample_q[6:0]);

    pos = 2'd0;
    case (sample_q[10:7])
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos = 2'd0;
    endcase

    digit_d  = digit_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
    seenNext = seen_q | (4'b0001 << pos);

    if (bus.clear) begin
      valid_d = '0;
      err_d   = '0;
      seen_d  = '0;
    end else if (accept) begin
      if (decOk) begin
        digit_d[pos] = decVal;
        valid_d[pos] = 1'b1;
      end else begin
        err_d[pos] = 1'b1;
      end
      if (seenNext == 4'b1111) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seenNext;
      end
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= SAMPLE_IDLE;
      run_q    <= '0;
      fired_q  <= 1'b0;
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
      valid_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      run_q    <= run_d;
      fired_q  <= fired_d;
      for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
      valid_q  <= valid_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.digit0     = digit_q[0];
  assign bus.digit1     = digit_q[1];
  assign bus.digit2     = digit_q[2];
  assign bus.digit3     = digit_q[3];
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_q;

endmodule
